// File: rtl/gravador_hd.sv
// rtl/gravador_hd.sv - copies a RAM image into a fixed-size HD block and records its length
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   request strobe, sampled only while idle
//   block_num, src_base,    destination block, first RAM word and word count,
//   length                  latched when a request is accepted
//   ram_addr / ram_rdata    synchronous RAM read port (data one cycle after address)
//   hd_addr, hd_wdata,      HD write port, one word per cycle with hd_we high
//   hd_we
//   size_sel / size_out     combinational size-table read (0 for out-of-range index)
//   busy, done, error       status: busy outside IDLE, done pulse per request,
//                           error pulse with done when the request was rejected
module gravador_hd #(
   parameter int unsigned BLOCK_SIZE = 200,
   parameter int unsigned NUM_BLOCKS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  block_num,
   input  logic [31:0] src_base,
   input  logic [31:0] length,
   output logic [31:0] ram_addr,
   input  logic [31:0] ram_rdata,
   output logic [31:0] hd_addr,
   output logic [31:0] hd_wdata,
   output logic        hd_we,
   input  logic [7:0]  size_sel,
   output logic [31:0] size_out,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned IW = $clog2(NUM_BLOCKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_UPD,
      S_DONE
   } state_t;

   state_t        state;
   logic [IW-1:0] blk_q;
   logic [31:0]   src_q;
   logic [31:0]   len_q;
   logic [31:0]   base_q;
   logic [31:0]   count;
   logic [31:0]   count_next;
   logic          req_ok;
   logic [31:0]   size_table [NUM_BLOCKS];

   assign count_next = count + 32'd1;

   assign req_ok = (length != 32'd0) && (length <= BLOCK_SIZE) &&
                   (32'(block_num) < NUM_BLOCKS);

   // The RAM returns data one cycle after the address, so during WR the
   // read port already holds the word addressed in the preceding RD cycle.
   assign hd_wdata = ram_rdata;

   assign size_out = (32'(size_sel) < NUM_BLOCKS) ? size_table[size_sel[IW-1:0]] : 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         blk_q    <= '0;
         src_q    <= '0;
         len_q    <= '0;
         base_q   <= '0;
         count    <= '0;
         ram_addr <= '0;
         hd_addr  <= '0;
         hd_we    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         for (int i = 0; i < int'(NUM_BLOCKS); i++) begin
            size_table[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (req_ok) begin
                     blk_q    <= block_num[IW-1:0];
                     src_q    <= src_base;
                     len_q    <= length;
                     base_q   <= 32'(block_num) * BLOCK_SIZE;
                     count    <= '0;
                     ram_addr <= src_base;
                     state    <= S_RD;
                  end else begin
                     // Rejected request: straight to DONE, HD and table untouched.
                     done  <= 1'b1;
                     error <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_RD: begin
               // Write strobe and address are set up here so they are
               // valid for the whole WR cycle.
               hd_we   <= 1'b1;
               hd_addr <= base_q + count;
               state   <= S_WR;
            end
            S_WR: begin
               hd_we <= 1'b0;
               count <= count_next;
               if (count_next == len_q) begin
                  state <= S_UPD;
               end else begin
                  ram_addr <= src_q + count_next;
                  state    <= S_RD;
               end
            end
            S_UPD: begin
               size_table[blk_q] <= len_q;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               error <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               hd_we <= 1'b0;
               done  <= 1'b0;
               error <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gravador_hd.sv
// tb/tb_gravador_hd.sv - directed vector bench for gravador_hd
module tb_gravador_hd;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  block_num;
   logic [31:0] src_base;
   logic [31:0] length;
   logic [31:0] ram_addr;
   logic [31:0] ram_rdata;
   logic [31:0] hd_addr;
   logic [31:0] hd_wdata;
   logic        hd_we;
   logic [7:0]  size_sel;
   logic [31:0] size_out;
   logic        busy;
   logic        done;
   logic        error;

   int checks;
   int failures;
   logic [31:0] exp_tab [8];

   typedef struct {
      logic [7:0]  blk;
      logic [31:0] src;
      logic [31:0] len;
      bit          err;
      bit          poke;
   } vec_t;

   vec_t vecs [9];

   gravador_hd #(.BLOCK_SIZE(200), .NUM_BLOCKS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .block_num (block_num),
      .src_base  (src_base),
      .length    (length),
      .ram_addr  (ram_addr),
      .ram_rdata (ram_rdata),
      .hd_addr   (hd_addr),
      .hd_wdata  (hd_wdata),
      .hd_we     (hd_we),
      .size_sel  (size_sel),
      .size_out  (size_out),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Synchronous-read RAM model: data appears one cycle after the address.
   always @(posedge clk) ram_rdata <= ram_word(ram_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; leaves at the negedge of the first IDLE cycle,
   // so consecutive calls issue back-to-back requests.
   task automatic run_req(input vec_t v);
      int n;
      int k;
      bit seen;
      logic [31:0] exp_size;
      if (v.err) exp_size = (v.blk < 8) ? exp_tab[v.blk[2:0]] : 32'd0;
      else       exp_size = v.len;
      size_sel  = v.blk;
      block_num = v.blk;
      src_base  = v.src;
      length    = v.len;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      block_num = 8'd5;
      src_base  = 32'hDEAD0000;
      length    = 32'd1;
      n = 0;
      k = 0;
      seen = 1'b0;
      while (!seen && n < 450) begin
         @(negedge clk);
         n++;
         if (v.poke && n == 3) start = 1'b1;
         if (v.poke && n == 4) start = 1'b0;
         if (!v.err && (n % 2 == 1) && (n < 2 * int'(v.len) + 1))
            chk("ram_addr", ram_addr, v.src + 32'((n - 1) / 2));
         if (hd_we) begin
            chk("wr_cycle", 32'(n), 32'(2 * k + 2));
            chk("hd_addr", hd_addr, 32'(v.blk) * 32'd200 + 32'(k));
            chk("hd_wdata", hd_wdata, ram_word(v.src + 32'(k)));
            k++;
         end
         if (done) begin
            seen = 1'b1;
            chk("done_cycle", 32'(n), v.err ? 32'd1 : 32'(2 * int'(v.len) + 2));
            chk("error", 32'(error), 32'(v.err));
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("size_out", size_out, exp_size);
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      chk("write_count", 32'(k), v.err ? 32'd0 : v.len);
      if (!v.err) exp_tab[v.blk[2:0]] = v.len;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      start     = 1'b0;
      block_num = '0;
      src_base  = '0;
      length    = '0;
      size_sel  = '0;
      for (int i = 0; i < 8; i++) exp_tab[i] = '0;

      vecs[0] = '{blk: 8'd2,   src: 32'h00000100, len: 32'd3,   err: 1'b0, poke: 1'b0};
      vecs[1] = '{blk: 8'd7,   src: 32'h00002000, len: 32'd200, err: 1'b0, poke: 1'b0};
      vecs[2] = '{blk: 8'd3,   src: 32'h00000040, len: 32'd201, err: 1'b1, poke: 1'b0};
      vecs[3] = '{blk: 8'd3,   src: 32'h00000040, len: 32'd0,   err: 1'b1, poke: 1'b0};
      vecs[4] = '{blk: 8'd8,   src: 32'h00000000, len: 32'd4,   err: 1'b1, poke: 1'b0};
      vecs[5] = '{blk: 8'd3,   src: 32'hFFFFFFFF, len: 32'd2,   err: 1'b0, poke: 1'b0};
      vecs[6] = '{blk: 8'd2,   src: 32'h00000300, len: 32'd1,   err: 1'b0, poke: 1'b0};
      vecs[7] = '{blk: 8'd255, src: 32'h00000010, len: 32'd5,   err: 1'b1, poke: 1'b0};
      vecs[8] = '{blk: 8'd4,   src: 32'h00000500, len: 32'd4,   err: 1'b0, poke: 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hd_we", 32'(hd_we), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_hd_addr", hd_addr, 32'd0);
      for (int i = 0; i < 8; i++) begin
         size_sel = 8'(i);
         #1;
         chk("rst_size_out", size_out, 32'd0);
      end
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_req(vecs[i]);

      // Table after all vectors: block 2 rewritten shorter, block 5 never written.
      for (int i = 0; i < 8; i++) begin
         size_sel = 8'(i);
         #1;
         chk("table_final", size_out, exp_tab[i]);
      end
      @(negedge clk);

      // Reset during cycle 3 of a length-5 transfer into block 3.
      size_sel  = 8'd3;
      block_num = 8'd3;
      src_base  = 32'h00000800;
      length    = 32'd5;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_hd_we", 32'(hd_we), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_ram_addr", ram_addr, 32'd0);
      chk("mid_rst_hd_addr", hd_addr, 32'd0);
      chk("mid_rst_size3", size_out, 32'd0);
      size_sel = 8'd7;
      #1;
      chk("mid_rst_size7", size_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) exp_tab[i] = '0;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_hd_we", 32'(hd_we), 32'd0);
      run_req('{blk: 8'd3, src: 32'h00000010, len: 32'd2, err: 1'b0, poke: 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
